// File: rtl/sysdef.sv
// Shared AES ingress definitions: block geometry and the controller-facing packet type.
package sysdef;

    localparam int unsigned AES_BLOCK_W = 128;
    localparam int unsigned AES_WORD_W  = 32;
    localparam int unsigned AES_BEATS   = 4;

    typedef struct packed {
        logic                   valid;
        logic                   set_key;
        logic [AES_BLOCK_W-1:0] data;
    } in_packet_t;

    typedef struct packed {
        logic                   set_key;
        logic [AES_BLOCK_W-1:0] data;
    } fifo_entry_t;

endpackage

// File: rtl/aes_pkt_fifo.sv
// Synchronous FIFO of tagged 128-bit blocks with count-decoded full/empty flags.
module aes_pkt_fifo
    import sysdef::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push,
    input  fifo_entry_t                push_data,
    input  logic                       pop,
    output fifo_entry_t                pop_data,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH+1);

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    fifo_entry_t      r_mem [DEPTH];

    logic w_full;
    logic w_empty;
    logic w_do_push;
    logic w_do_pop;

    assign w_full    = (r_count == CNT_W'(DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_do_push = push && !w_full && !flush;
    assign w_do_pop  = pop && !w_empty && !flush;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_do_pop && !w_do_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    assign pop_data = r_mem[r_rd_ptr];
    assign count    = r_count;
    assign full     = w_full;
    assign empty    = w_empty;

endmodule

// File: rtl/aes_input_buffer.sv
// Host ingress: packs 32-bit beats into tagged 128-bit blocks, queues them, and presents
// one registered packet at a time to the AES controller.
module aes_input_buffer
    import sysdef::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       wr_valid,
    output logic                       wr_ready,
    input  logic [AES_WORD_W-1:0]      wr_data,
    input  logic                       wr_set_key,
    input  logic                       load_data,
    output in_packet_t                 data_out,
    output logic [$clog2(DEPTH+1)-1:0] fifo_count,
    output logic                       fifo_full,
    output logic                       fifo_empty
);

    localparam int unsigned ACC_W = AES_BLOCK_W - AES_WORD_W;

    logic [1:0]       r_beat_cnt;
    logic [ACC_W-1:0] r_accum;
    logic             r_set_key;
    in_packet_t       r_data_out;

    logic        w_wr_ready;
    logic        w_beat_acc;
    logic        w_push;
    logic        w_pop;
    logic        w_full;
    logic        w_empty;
    fifo_entry_t w_push_data;
    fifo_entry_t w_head;

    // No pop bypass on beat 3, so load_data never reaches wr_ready.
    assign w_wr_ready = !flush && ((r_beat_cnt != 2'd3) || !w_full);
    assign w_beat_acc = wr_valid && w_wr_ready;
    assign w_push     = w_beat_acc && (r_beat_cnt == 2'd3);
    assign w_pop      = load_data && !w_empty && !flush;

    assign w_push_data.set_key = r_set_key;
    assign w_push_data.data    = {r_accum, wr_data};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_beat_cnt <= '0;
            r_accum    <= '0;
            r_set_key  <= 1'b0;
        end else if (flush) begin
            r_beat_cnt <= '0;
            r_accum    <= '0;
            r_set_key  <= 1'b0;
        end else if (w_beat_acc) begin
            r_beat_cnt <= r_beat_cnt + 1'b1;
            case (r_beat_cnt)
                2'd0: begin
                    r_accum[95:64] <= wr_data;
                    r_set_key      <= wr_set_key;
                end
                2'd1:    r_accum[63:32] <= wr_data;
                2'd2:    r_accum[31:0]  <= wr_data;
                default: ;
            endcase
        end
    end

    aes_pkt_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .push      (w_push),
        .push_data (w_push_data),
        .pop       (w_pop),
        .pop_data  (w_head),
        .count     (fifo_count),
        .full      (w_full),
        .empty     (w_empty)
    );

    // A packet is held until exactly one load_data edge consumes it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data_out <= '0;
        end else if (flush) begin
            r_data_out <= '0;
        end else if (load_data) begin
            if (!w_empty) begin
                r_data_out <= {1'b1, w_head.set_key, w_head.data};
            end else begin
                r_data_out <= '0;
            end
        end
    end

    assign wr_ready   = w_wr_ready;
    assign data_out   = r_data_out;
    assign fifo_full  = w_full;
    assign fifo_empty = w_empty;

endmodule

// File: tb/tb_aes_input_buffer.sv
// Directed self-checking bench for aes_input_buffer with DEPTH=4.
module tb_aes_input_buffer;
    import sysdef::*;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        wr_valid;
    logic        wr_ready;
    logic [31:0] wr_data;
    logic        wr_set_key;
    logic        load_data;
    in_packet_t  data_out;
    logic [2:0]  fifo_count;
    logic        fifo_full;
    logic        fifo_empty;

    int n_pass;
    int n_total;

    aes_input_buffer #(
        .DEPTH (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_data    (wr_data),
        .wr_set_key (wr_set_key),
        .load_data  (load_data),
        .data_out   (data_out),
        .fifo_count (fifo_count),
        .fifo_full  (fifo_full),
        .fifo_empty (fifo_empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] blk(input int n);
        logic [7:0] t;
        t = n[7:0];
        return {t, 24'h000000, t, 24'h000001, t, 24'h000002, t, 24'h000003};
    endfunction

    // Drives beats first..last of block d; later beats carry an inverted key that must be ignored.
    task automatic send_beats(input logic key, input logic [127:0] d, input int first,
                              input int last);
        for (int j = first; j <= last; j++) begin
            wr_valid   = 1'b1;
            wr_data    = d[127-32*j -: 32];
            wr_set_key = (j == 0) ? key : ~key;
            tick();
        end
        wr_valid = 1'b0;
    endtask

    task automatic send_block(input logic key, input logic [127:0] d);
        send_beats(key, d, 0, 3);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_total++;
        if (data_out !== '0) $display("FAIL reset_data got %h want 0", data_out);
        else n_pass++;
        n_total++;
        if (fifo_count !== 3'd0) $display("FAIL reset_count got %0d want 0", fifo_count);
        else n_pass++;
        n_total++;
        if (fifo_empty !== 1'b1 || fifo_full !== 1'b0)
            $display("FAIL reset_flags got e=%b f=%b want e=1 f=0", fifo_empty, fifo_full);
        else n_pass++;
        rst = 1'b0;
        #1;
        n_total++;
        if (wr_ready !== 1'b1) $display("FAIL reset_wr_ready got %b want 1", wr_ready);
        else n_pass++;
    endtask

    task automatic test_single_block();
        in_packet_t exp;
        logic [127:0] d;
        d = 128'h000102030405060708090A0B0C0D0E0F;
        exp = {1'b1, 1'b1, d};
        load_data = 1'b1;
        send_block(1'b1, d);
        n_total++;
        if (data_out.valid !== 1'b0) $display("FAIL single_early got %b want 0", data_out.valid);
        else n_pass++;
        tick();
        n_total++;
        if (data_out !== exp) $display("FAIL single_data got %h want %h", data_out, exp);
        else n_pass++;
        tick();
        n_total++;
        if (data_out.valid !== 1'b0) $display("FAIL single_bubble got %b want 0", data_out.valid);
        else n_pass++;
        load_data = 1'b0;
    endtask

    task automatic test_full_backpressure();
        in_packet_t exp;
        load_data = 1'b0;
        for (int n = 1; n <= 4; n++) send_block(n[0], blk(n));
        n_total++;
        if (fifo_count !== 3'd4 || fifo_full !== 1'b1)
            $display("FAIL full_flag got cnt=%0d f=%b want cnt=4 f=1", fifo_count, fifo_full);
        else n_pass++;
        send_beats(1'b1, blk(5), 0, 2);
        wr_valid = 1'b1;
        wr_data  = blk(5) & 128'hFFFFFFFF;
        #1;
        n_total++;
        if (wr_ready !== 1'b0) $display("FAIL full_ready_beat3 got %b want 0", wr_ready);
        else n_pass++;
        tick();
        n_total++;
        if (fifo_count !== 3'd4) $display("FAIL full_no_accept got %0d want 4", fifo_count);
        else n_pass++;
        load_data = 1'b1;
        tick();
        load_data = 1'b0;
        exp = {1'b1, 1'b1, blk(1)};
        n_total++;
        if (data_out !== exp) $display("FAIL full_pop1 got %h want %h", data_out, exp);
        else n_pass++;
        n_total++;
        if (fifo_count !== 3'd3 || wr_ready !== 1'b1)
            $display("FAIL full_after_pop got cnt=%0d rdy=%b want 3 1", fifo_count, wr_ready);
        else n_pass++;
        tick();
        wr_valid = 1'b0;
        n_total++;
        if (fifo_count !== 3'd4) $display("FAIL full_blk5_accept got %0d want 4", fifo_count);
        else n_pass++;
        n_total++;
        if (data_out !== exp) $display("FAIL full_hold got %h want %h", data_out, exp);
        else n_pass++;
        load_data = 1'b1;
        for (int n = 2; n <= 5; n++) begin
            tick();
            exp = {1'b1, n[0], blk(n)};
            n_total++;
            if (data_out !== exp) $display("FAIL full_drain%0d got %h want %h", n, data_out, exp);
            else n_pass++;
        end
        tick();
        n_total++;
        if (data_out.valid !== 1'b0 || fifo_empty !== 1'b1)
            $display("FAIL full_end got v=%b e=%b want 0 1", data_out.valid, fifo_empty);
        else n_pass++;
        load_data = 1'b0;
    endtask

    task automatic test_hold();
        in_packet_t exp_a;
        in_packet_t exp_b;
        logic       ld_seq [5];
        exp_a  = {1'b1, 1'b0, blk(6)};
        exp_b  = {1'b1, 1'b1, blk(7)};
        ld_seq = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        send_block(1'b0, blk(6));
        send_block(1'b1, blk(7));
        for (int i = 0; i < 5; i++) begin
            load_data = ld_seq[i];
            tick();
            n_total++;
            if (i < 3) begin
                if (data_out !== exp_a) $display("FAIL hold_a%0d got %h want %h", i, data_out, exp_a);
                else n_pass++;
            end else if (i == 3) begin
                if (data_out !== exp_b) $display("FAIL hold_b got %h want %h", data_out, exp_b);
                else n_pass++;
            end else begin
                if (data_out !== '0) $display("FAIL hold_end got %h want 0", data_out);
                else n_pass++;
            end
        end
        load_data = 1'b0;
    endtask

    task automatic test_reset_mid_block();
        in_packet_t exp;
        send_block(1'b1, blk(8));
        send_block(1'b0, blk(9));
        send_block(1'b1, blk(10));
        load_data = 1'b1;
        tick();
        load_data = 1'b0;
        exp = {1'b1, 1'b1, blk(8)};
        n_total++;
        if (data_out !== exp || fifo_count !== 3'd2)
            $display("FAIL rstmid_pre got %h cnt=%0d want %h cnt=2", data_out, fifo_count, exp);
        else n_pass++;
        send_beats(1'b0, blk(11), 0, 2);
        #2 rst = 1'b1;
        #1;
        n_total++;
        if (data_out !== '0 || fifo_empty !== 1'b1 || fifo_count !== 3'd0)
            $display("FAIL rstmid_async got %h e=%b cnt=%0d want 0 1 0", data_out, fifo_empty,
                     fifo_count);
        else n_pass++;
        @(posedge clk);
        #1 rst = 1'b0;
        send_block(1'b0, blk(12));
        load_data = 1'b1;
        tick();
        load_data = 1'b0;
        exp = {1'b1, 1'b0, blk(12)};
        n_total++;
        if (data_out !== exp) $display("FAIL rstmid_fresh got %h want %h", data_out, exp);
        else n_pass++;
    endtask

    task automatic test_flush();
        in_packet_t exp;
        for (int n = 13; n <= 16; n++) send_block(n[0], blk(n));
        load_data = 1'b1;
        tick();
        load_data = 1'b0;
        send_beats(1'b1, blk(17), 0, 1);
        flush      = 1'b1;
        wr_valid   = 1'b1;
        wr_data    = 32'hDEADBEEF;
        wr_set_key = 1'b1;
        #1;
        n_total++;
        if (wr_ready !== 1'b0) $display("FAIL flush_ready got %b want 0", wr_ready);
        else n_pass++;
        tick();
        flush    = 1'b0;
        wr_valid = 1'b0;
        n_total++;
        if (fifo_count !== 3'd0 || fifo_empty !== 1'b1 || data_out !== '0)
            $display("FAIL flush_clear got cnt=%0d e=%b d=%h want 0 1 0", fifo_count, fifo_empty,
                     data_out);
        else n_pass++;
        send_block(1'b0, blk(18));
        load_data = 1'b1;
        tick();
        load_data = 1'b0;
        exp = {1'b1, 1'b0, blk(18)};
        n_total++;
        if (data_out !== exp) $display("FAIL flush_restart got %h want %h", data_out, exp);
        else n_pass++;
    endtask

    task automatic test_stream();
        in_packet_t exp;
        load_data = 1'b1;
        for (int k = 0; k < 12; k++) begin
            send_block(k[0], blk(20 + k));
            tick();
            exp = {1'b1, k[0], blk(20 + k)};
            n_total++;
            if (data_out !== exp) $display("FAIL stream%0d got %h want %h", k, data_out, exp);
            else n_pass++;
        end
        tick();
        n_total++;
        if (data_out.valid !== 1'b0 || fifo_empty !== 1'b1)
            $display("FAIL stream_end got v=%b e=%b want 0 1", data_out.valid, fifo_empty);
        else n_pass++;
        load_data = 1'b0;
    endtask

    initial begin
        n_pass     = 0;
        n_total    = 0;
        rst        = 1'b1;
        flush      = 1'b0;
        wr_valid   = 1'b0;
        wr_data    = '0;
        wr_set_key = 1'b0;
        load_data  = 1'b0;
        test_reset();
        test_single_block();
        test_full_backpressure();
        test_hold();
        test_reset_mid_block();
        test_flush();
        test_stream();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/aes_input_buffer.md
Name: aes_input_buffer

Overview:
Host-side ingress stage that sits directly upstream of the AES controller and supplies its in_packet_t input.
- Packs 32-bit host write beats into 128-bit blocks, tagging each block as a key or a data block.
- Queues completed blocks in a DEPTH-entry FIFO.
- Presents one registered packet at a time on data_out, advancing only when the consumer asserts load_data.

Parameters:
DEPTH, 4, number of 128-bit block entries in the FIFO; power of two, minimum 2.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-high reset.
flush  input  1  synchronous clear of packer, FIFO and output register.
wr_valid  input  1  host beat valid.
wr_ready  output  1  beat accepted when wr_valid && wr_ready at a rising edge.
wr_data  input  32  host beat; beat 0 = block[127:96] … beat 3 = block[31:0].
wr_set_key  input  1  block type flag (1 = key block); sampled on beat 0 only.
load_data  input  1  consumer advance request.
data_out  output  in_packet_t  {valid, set_key, data[127:0]}; registered.
fifo_count  output  $clog2(DEPTH+1)  occupied FIFO entries.
fifo_full  output  1  fifo_count == DEPTH.
fifo_empty  output  1  fifo_count == 0.

Behaviour:
Reset (rst=1, asynchronous) clears:
- beat counter to 0, accumulator to 0, pointers to 0;
- data_out to all-zero (valid=0); fifo_count to 0;
- fifo_empty=1, fifo_full=0.
- wr_ready reads 1 after reset deasserts. Reset mid-block discards all partial beats.

Packer:
- 2-bit beat counter, incremented on each accepted beat, wraps 3→0.
- Beats 0–2 are stored in a 96-bit accumulator. Beat 0 also latches wr_set_key.
- On accepted beat 3, {set_key, accum, wr_data} is pushed into the FIFO in the same edge.
- wr_ready = !flush && (beat_cnt != 3 || !fifo_full).
- No bypass: a same-cycle pop does not free space for beat 3. This keeps load_data off the wr_ready path.

FIFO:
- Registered storage, read/write pointers wrap modulo DEPTH.
- fifo_count updates: +1 on push only, −1 on pop only, unchanged on simultaneous push and pop.
- fifo_full and fifo_empty are decoded from fifo_count.

Output register:
- At a rising edge with load_data=1:
  - FIFO non-empty: pop the head; data_out <= {1, head.set_key, head.data}.
  - FIFO empty: data_out <= 0.
- At a rising edge with load_data=0: data_out holds, even when valid=1 (no auto-drop).
- A packet on data_out is consumed by exactly one load_data edge.

Latency:
- A block completed at edge t is in the FIFO after t.
- If it reaches the head of an empty FIFO, it appears on data_out at the first edge ≥ t+1 with load_data=1.
- A push at edge t is not visible to a pop at the same edge t.

Flush (synchronous, priority over everything except rst):
- Clears beat counter, FIFO pointers/count and data_out.
- No beat is accepted in the flush cycle (wr_ready=0).

Boundaries:
- FIFO full and beat_cnt=3: wr_ready=0 until a pop has completed.
- FIFO empty and load_data=1: valid=0 bubbles on data_out.
- Pointer wrap at DEPTH−1→0 is seamless.
- wr_set_key on beats 1–3 is ignored.

Decomposition:
Shared package sysdef:
- in_packet_t (valid, set_key, data[127:0]);
- AES_BLOCK_W=128, AES_WORD_W=32, AES_BEATS=4.

Natural sub-module: aes_pkt_fifo.
- Parameterised synchronous FIFO of {set_key, data[127:0]}.
- Ports push/pop/flush/count/full/empty.
- Packer and output register stay in aes_input_buffer.

Test Plan:
- Reset then 4 beats 0x00010203, 0x04050607, 0x08090A0B, 0x0C0D0E0F with wr_set_key=1 on beat 0, load_data held 1 → one cycle after beat 3, data_out = {1, 1, 0x000102030405060708090A0B0C0D0E0F}; next edge valid=0.
- DEPTH=4, load_data=0, push 5 blocks → fifo_full=1 after block 4; wr_ready drops at beat 3 of block 5; raise load_data for 1 cycle → block 1 on data_out, count=3; block 5 accepted next edge.
- load_data toggled 1,0,0,1 with 2 queued blocks → block A presented, held 2 cycles, then block B; A never repeats, B never skipped.
- Assert rst after beat 2 of a block with 2 entries queued → data_out=0, fifo_empty=1 immediately (asynchronous); next 4 beats form a fresh block.
- flush for one cycle with wr_valid=1 mid-block and 3 entries queued → beat not accepted, count=0, data_out valid=0, beat counter restarts at 0.
- Stream 12 blocks with continuous load_data=1 and alternating set_key → in-order output, correct set_key per block, pointer wrap exercised three times.
